// File: rtl/fetch_unit_bp_if.sv
// fetch_unit_bp_if: groups the fetch front end's bus signals.
//   master modport: the fetch unit (drives imem_addr and the IF/ID outputs,
//                   receives stall, redirect, BTB update and imem_rdata).
//   slave modport:  the surrounding pipeline (hazard unit, EX branch unit,
//                   instruction memory, decode stage).
// Signals:
//   stall                          hold PC and IF/ID
//   redirect_valid, redirect_pc    refetch from a corrected address
//   update_valid/pc/taken/target   resolved branch/jump for BTB training
//   imem_addr, imem_rdata          combinational-read instruction memory
//   ifid_valid/pc/instr/pred_*     IF/ID pipeline register contents
interface fetch_unit_bp_if #(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned INS_W = 32
);
    logic             stall;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             update_valid;
    logic [PC_W-1:0]  update_pc;
    logic             update_taken;
    logic [PC_W-1:0]  update_target;
    logic [PC_W-1:0]  imem_addr;
    logic [INS_W-1:0] imem_rdata;
    logic             ifid_valid;
    logic [PC_W-1:0]  ifid_pc;
    logic [INS_W-1:0] ifid_instr;
    logic             ifid_pred_taken;
    logic [PC_W-1:0]  ifid_pred_target;

    modport master (
        input  stall, redirect_valid, redirect_pc,
        input  update_valid, update_pc, update_taken, update_target,
        input  imem_rdata,
        output imem_addr,
        output ifid_valid, ifid_pc, ifid_instr, ifid_pred_taken, ifid_pred_target
    );

    modport slave (
        output stall, redirect_valid, redirect_pc,
        output update_valid, update_pc, update_taken, update_target,
        output imem_rdata,
        input  imem_addr,
        input  ifid_valid, ifid_pc, ifid_instr, ifid_pred_taken, ifid_pred_target
    );
endinterface

// File: rtl/fetch_unit_bp.sv
// fetch_unit_bp: RV32I instruction-fetch front end with a direct-mapped BTB.
// Holds the PC, drives the instruction memory address, owns the IF/ID register
// and predicts taken branches with 2-bit saturating counters.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    fetch_unit_bp_if.master (stall, redirect, BTB update, imem, IF/ID)
//   perf_fetch_cnt, perf_redirect_cnt  (only with FETCH_PERF_CNT_EN defined)
//          count IF/ID captures and redirects; wrap at 2^32.
// Optional feature macro: FETCH_PERF_CNT_EN.
module fetch_unit_bp #(
    parameter int unsigned     PC_W        = 9,
    parameter int unsigned     INS_W       = 32,
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic        clk,
    input  logic        reset,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_redirect_cnt,
`endif
    fetch_unit_bp_if.master bus
);
    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;

    // PC register
    logic [PC_W-1:0] pc_q, pc_d;

    // BTB storage; only the valid bits are reset
    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [TAG_W-1:0]       btb_tag_q    [BTB_ENTRIES];
    logic [PC_W-1:0]        btb_target_q [BTB_ENTRIES];
    logic [1:0]             btb_ctr_q    [BTB_ENTRIES];

    // IF/ID register
    logic             ifid_valid_q;
    logic [PC_W-1:0]  ifid_pc_q;
    logic [INS_W-1:0] ifid_instr_q;
    logic             ifid_pred_taken_q;
    logic [PC_W-1:0]  ifid_pred_target_q;

    // Lookup on the current PC (sees pre-update BTB contents)
    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_hit;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;

    assign rd_idx      = pc_q[IDX_W+1:2];
    assign rd_tag      = pc_q[PC_W-1:IDX_W+2];
    assign rd_hit      = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == rd_tag);
    assign pred_taken  = rd_hit && btb_ctr_q[rd_idx][1];
    assign pred_target = btb_target_q[rd_idx];

    // Next-PC selection
    always_comb begin
        pc_d = pc_q;
        if (reset) begin
            pc_d = RESET_PC;
        end else if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end else begin
            pc_d = pc_q + PC_W'(4);  // wraps modulo 2^PC_W
        end
    end

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    // IF/ID register: reset and redirect insert a bubble, stall holds
    always_ff @(posedge clk) begin
        if (reset || bus.redirect_valid) begin
            ifid_valid_q       <= 1'b0;
            ifid_pc_q          <= '0;
            ifid_instr_q       <= '0;
            ifid_pred_taken_q  <= 1'b0;
            ifid_pred_target_q <= '0;
        end else if (!bus.stall) begin
            ifid_valid_q       <= 1'b1;
            ifid_pc_q          <= pc_q;
            ifid_instr_q       <= bus.imem_rdata;
            ifid_pred_taken_q  <= pred_taken;
            ifid_pred_target_q <= pred_taken ? pred_target : '0;
        end
    end

    // BTB update decode
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;
    logic [1:0]       wr_ctr_cur;
    logic [1:0]       wr_ctr_nxt;

    assign wr_idx     = bus.update_pc[IDX_W+1:2];
    assign wr_tag     = bus.update_pc[PC_W-1:IDX_W+2];
    assign wr_hit     = btb_valid_q[wr_idx] && (btb_tag_q[wr_idx] == wr_tag);
    assign wr_ctr_cur = btb_ctr_q[wr_idx];

    always_comb begin
        wr_ctr_nxt = wr_ctr_cur;
        if (bus.update_taken) begin
            if (wr_ctr_cur != 2'b11) wr_ctr_nxt = wr_ctr_cur + 2'b01;
        end else begin
            if (wr_ctr_cur != 2'b00) wr_ctr_nxt = wr_ctr_cur - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btb_valid_q <= '0;
        end else if (bus.update_valid && !wr_hit && bus.update_taken) begin
            btb_valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && bus.update_valid) begin
            if (wr_hit) begin
                btb_ctr_q[wr_idx] <= wr_ctr_nxt;
                if (bus.update_taken) btb_target_q[wr_idx] <= bus.update_target;
            end else if (bus.update_taken) begin
                // Allocate, evicting whatever aliases at this index
                btb_tag_q[wr_idx]    <= wr_tag;
                btb_target_q[wr_idx] <= bus.update_target;
                btb_ctr_q[wr_idx]    <= 2'b10;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_redirect_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q    <= '0;
            perf_redirect_q <= '0;
        end else begin
            if (bus.redirect_valid) begin
                perf_redirect_q <= perf_redirect_q + 32'd1;
            end else if (!bus.stall) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt    = perf_fetch_q;
    assign perf_redirect_cnt = perf_redirect_q;
`endif

    assign bus.imem_addr        = pc_q;
    assign bus.ifid_valid       = ifid_valid_q;
    assign bus.ifid_pc          = ifid_pc_q;
    assign bus.ifid_instr       = ifid_instr_q;
    assign bus.ifid_pred_taken  = ifid_pred_taken_q;
    assign bus.ifid_pred_target = ifid_pred_target_q;
endmodule
